traffic_intersection_model: RTL and testbench

- Environment-side counterpart of the traffic-light controller FSM.
- Consumes the two light codes SA/SB and produces the street sensors TA/TB, so the controller can run closed-loop on the board and in simulation.
- Models one car queue per street: cars arrive on pulses and leave one at a time while their light is green.
- Also checks the light protocol and flags illegal codes, conflicting greens and bad phase order.

---
 rtl/traffic_intersection_model_pkg.sv | 34 +++
 rtl/street_queue.sv | 61 ++++++
 rtl/traffic_intersection_model.sv | 94 +++++++++
 tb/tb_traffic_intersection_model.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_intersection_model_pkg.sv
// ---------------------------------------------------------------------------
// traffic_intersection_model_pkg : light codes, error indices, phase-order rule
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package traffic_intersection_model_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_BAD    = 2'b11;

  localparam int ERR_CODE     = 0;
  localparam int ERR_CONFLICT = 1;
  localparam int ERR_ORDER    = 2;

  // Holding a code is always legal; otherwise only green->yellow->red->green.
  function automatic logic legal_transition(input logic [1:0] prev_code,
                                            input logic [1:0] cur_code);
    logic ok;
    ok = (prev_code == cur_code);
    case (prev_code)
      LIGHT_GREEN:  ok = ok | (cur_code == LIGHT_YELLOW);
      LIGHT_YELLOW: ok = ok | (cur_code == LIGHT_RED);
      LIGHT_RED:    ok = ok | (cur_code == LIGHT_GREEN);
      default:      ok = ok;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/street_queue.sv
// ---------------------------------------------------------------------------
// street_queue : saturating car queue with a green-time departure timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module street_queue #(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive,
  input  logic          green,
  output logic [QW-1:0] count,
  output logic          sensor,
  output logic          ovf
);

  localparam logic [QW-1:0] FULL      = '1;
  localparam logic [7:0]    LAST_TICK = 8'(PASS_CYCLES - 1);

  logic [QW-1:0] r_count;
  logic [7:0]    r_timer;
  logic          r_ovf;
  logic          w_active;
  logic          w_depart;

  assign w_active = green && (r_count != '0);
  assign w_depart = w_active && (r_timer == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // Timer only advances while a car is actually being served.
      if (w_active && !w_depart)
        r_timer <= r_timer + 8'd1;
      else
        r_timer <= '0;

      if (arrive && !w_depart) begin
        if (r_count == FULL)
          r_ovf <= 1'b1;
        else
          r_count <= r_count + QW'(1);
      end else if (!arrive && w_depart) begin
        r_count <= r_count - QW'(1);
      end
    end
  end

  assign count  = r_count;
  assign sensor = (r_count != '0);
  assign ovf    = r_ovf;

endmodule

`default_nettype wire

// File: rtl/traffic_intersection_model.sv
// ---------------------------------------------------------------------------
// traffic_intersection_model : two street queues driving TA/TB plus a light-protocol checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_intersection_model
  import traffic_intersection_model_pkg::*;
#(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [1:0]    SA,
  input  logic [1:0]    SB,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] count_a,
  output logic [QW-1:0] count_b,
  output logic [1:0]    ovf,
  output logic [2:0]    err,
  output logic          err_pulse
);

  logic       w_green_a;
  logic       w_green_b;
  logic       w_ovf_a;
  logic       w_ovf_b;
  logic [2:0] w_err;
  logic [1:0] r_prev_sa;
  logic [1:0] r_prev_sb;
  logic       r_prev_valid;
  logic [2:0] r_err;
  logic       r_err_pulse;

  // Code 11 is not green, so it never releases a car.
  assign w_green_a = (SA == LIGHT_GREEN);
  assign w_green_b = (SB == LIGHT_GREEN);

  street_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES)) u_queue_a (
    .clk    (clk),
    .reset  (reset),
    .arrive (car_a),
    .green  (w_green_a),
    .count  (count_a),
    .sensor (TA),
    .ovf    (w_ovf_a)
  );

  street_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES)) u_queue_b (
    .clk    (clk),
    .reset  (reset),
    .arrive (car_b),
    .green  (w_green_b),
    .count  (count_b),
    .sensor (TB),
    .ovf    (w_ovf_b)
  );

  always_comb begin
    w_err               = '0;
    w_err[ERR_CODE]     = (SA == LIGHT_BAD) || (SB == LIGHT_BAD);
    w_err[ERR_CONFLICT] = (SA != LIGHT_RED) && (SB != LIGHT_RED);
    w_err[ERR_ORDER]    = r_prev_valid &&
                          (!legal_transition(r_prev_sa, SA) ||
                           !legal_transition(r_prev_sb, SB));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_sa    <= LIGHT_RED;
      r_prev_sb    <= LIGHT_RED;
      r_prev_valid <= 1'b0;
      r_err        <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_prev_sa    <= SA;
      r_prev_sb    <= SB;
      r_prev_valid <= 1'b1;
      r_err        <= r_err | w_err;
      r_err_pulse  <= |w_err;
    end
  end

  assign ovf       = {w_ovf_b, w_ovf_a};
  assign err       = r_err;
  assign err_pulse = r_err_pulse;

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_model.sv
// ---------------------------------------------------------------------------
// tb_traffic_intersection_model : directed and randomized closed-form checks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traffic_intersection_model;

  localparam int QW       = 4;
  localparam int PASS     = 3;
  localparam int MAXCARS  = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          car_a, car_b;
  logic [1:0]    SA, SB;
  logic          TA, TB;
  logic [QW-1:0] count_a, count_b;
  logic [1:0]    ovf;
  logic [2:0]    err;
  logic          err_pulse;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference state: cars waiting, green edges spent on the car at the front.
  int       m_cnt [2];
  int       m_served [2];
  bit       m_ovf [2];
  bit [2:0] m_err;
  bit       m_pulse;
  int       m_prev [2];
  bit       m_prev_valid;

  traffic_intersection_model #(.QW(QW), .PASS_CYCLES(PASS)) dut (
    .clk       (clk),
    .reset     (reset),
    .car_a     (car_a),
    .car_b     (car_b),
    .SA        (SA),
    .SB        (SB),
    .TA        (TA),
    .TB        (TB),
    .count_a   (count_a),
    .count_b   (count_b),
    .ovf       (ovf),
    .err       (err),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  // Allowed next code after each code (0 red->2 green, 1 yellow->0 red, 2 green->1 yellow).
  function automatic bit legal(int p, int c);
    int nxt [4];
    nxt = '{2, 0, 1, -1};
    return (p == c) || (nxt[p] == c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s]    = 0;
      m_served[s] = 0;
      m_ovf[s]    = 1'b0;
      m_prev[s]   = 0;
    end
    m_err        = '0;
    m_pulse      = 1'b0;
    m_prev_valid = 1'b0;
  endtask

  task automatic model_edge(input bit ca, input bit cb, input bit [1:0] sa, input bit [1:0] sb);
    int  code [2];
    int  arr [2];
    bit  bad_order;
    code[0] = int'(sa);
    code[1] = int'(sb);
    arr[0]  = int'(ca);
    arr[1]  = int'(cb);
    for (int s = 0; s < 2; s++) begin
      bit serving;
      int leaving;
      int n;
      serving = (code[s] == 2) && (m_cnt[s] > 0);
      leaving = (serving && (m_served[s] + 1 == PASS)) ? 1 : 0;
      m_served[s] = (serving && leaving == 0) ? m_served[s] + 1 : 0;
      n = m_cnt[s] + arr[s] - leaving;
      if (n > MAXCARS) begin
        n = MAXCARS;
        m_ovf[s] = 1'b1;
      end
      m_cnt[s] = n;
    end
    bad_order = m_prev_valid && (!legal(m_prev[0], code[0]) || !legal(m_prev[1], code[1]));
    m_pulse = (code[0] == 3 || code[1] == 3) || (code[0] != 0 && code[1] != 0) || bad_order;
    m_err = m_err | {bad_order, (code[0] != 0 && code[1] != 0), (code[0] == 3 || code[1] == 3)};
    m_prev[0]    = code[0];
    m_prev[1]    = code[1];
    m_prev_valid = 1'b1;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".count_a"},   32'(count_a),   32'(m_cnt[0]));
    check({ctx, ".count_b"},   32'(count_b),   32'(m_cnt[1]));
    check({ctx, ".TA"},        32'(TA),        32'(m_cnt[0] != 0));
    check({ctx, ".TB"},        32'(TB),        32'(m_cnt[1] != 0));
    check({ctx, ".ovf"},       32'(ovf),       32'({m_ovf[1], m_ovf[0]}));
    check({ctx, ".err"},       32'(err),       32'(m_err));
    check({ctx, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
  endtask

  // Inputs are applied just after an edge; the model advances on the next edge.
  task automatic step(input bit ca, input bit cb, input bit [1:0] sa, input bit [1:0] sb,
                      input string ctx);
    car_a = ca;
    car_b = cb;
    SA    = sa;
    SB    = sb;
    @(posedge clk);
    model_edge(ca, cb, sa, sb);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    reset = 1'b1;
    car_a = 1'b0;
    car_b = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int       ph;
    int       hold;
    bit [1:0] ra, rb;

    reset = 1'b1;
    car_a = 1'b0;
    car_b = 1'b0;
    SA    = 2'b00;
    SB    = 2'b00;
    #2;
    do_reset("rst0");

    // Queue A fills under red, then drains one car per three green edges.
    for (int i = 0; i < 5; i++) step(1, 0, 2'b00, 2'b00, "fill_a");
    for (int i = 0; i < 16; i++) step(0, 0, 2'b10, 2'b00, "drain_a");

    // Yellow holds the queue, red, then green releases on the third edge.
    step(1, 0, 2'b01, 2'b00, "yel_arr");
    step(1, 0, 2'b01, 2'b00, "yel_arr");
    for (int i = 0; i < 10; i++) step(0, 0, 2'b01, 2'b00, "yel_hold");
    step(0, 0, 2'b00, 2'b00, "red");
    for (int i = 0; i < 4; i++) step(0, 0, 2'b10, 2'b00, "green_again");

    // Saturation and overflow on B, then simultaneous arrival/departure at full.
    do_reset("rst_sat");
    for (int i = 0; i < 16; i++) step(0, 1, 2'b00, 2'b00, "fill_b");
    step(0, 0, 2'b00, 2'b10, "b_green1");
    step(0, 0, 2'b00, 2'b10, "b_green2");
    step(0, 1, 2'b00, 2'b10, "b_green3_arr");
    step(0, 0, 2'b00, 2'b10, "b_green4");

    // Conflicting greens, then illegal code as first post-reset sample.
    do_reset("rst_conf");
    step(0, 0, 2'b00, 2'b00, "conf_pre");
    step(0, 0, 2'b10, 2'b10, "conflict");
    do_reset("rst_bad");
    step(0, 0, 2'b11, 2'b10, "bad_code");

    // Skipping yellow is an order error; the full cycle is clean.
    do_reset("rst_ord");
    step(0, 0, 2'b10, 2'b00, "ord_g");
    step(0, 0, 2'b00, 2'b00, "ord_skip");
    do_reset("rst_legal");
    step(0, 0, 2'b10, 2'b00, "seq_g");
    step(0, 0, 2'b01, 2'b00, "seq_y");
    step(0, 0, 2'b00, 2'b00, "seq_r");
    step(0, 0, 2'b10, 2'b00, "seq_g2");

    // Reset lands while a car is part-way through its green time.
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 2'b00, "mid_fill");
    step(0, 0, 2'b10, 2'b00, "mid_tick");
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 2'b01, 2'b00, "post_rst_yel");

    // Closed-loop style run with a well-behaved phase sequence.
    do_reset("rst_rand");
    ph   = 0;
    hold = 0;
    for (int i = 0; i < 300; i++) begin
      if (hold == 0) begin
        ph   = (ph + 1) % 4;
        hold = (ph % 2 == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(1, 3));
      end
      hold--;
      case (ph)
        0:       begin ra = 2'b10; rb = 2'b00; end
        1:       begin ra = 2'b01; rb = 2'b00; end
        2:       begin ra = 2'b00; rb = 2'b10; end
        default: begin ra = 2'b00; rb = 2'b01; end
      endcase
      step(bit'($urandom_range(0, 99) < 35), bit'($urandom_range(0, 99) < 35), ra, rb, "rand_phase");
    end

    // Arbitrary codes, mostly held, to exercise the checker.
    do_reset("rst_wild");
    ra = 2'b00;
    rb = 2'b00;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 30) ra = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 30) rb = 2'($urandom_range(0, 3));
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra, rb, "rand_wild");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
